rvco_freq_meter: RTL and testbench



---
 rtl/rvco_freq_meter.sv | 157 +++++++++++++++
 tb/tb_rvco_freq_meter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvco_freq_meter.sv
// Ring-oscillator frequency meter: settles the selected oscillator, then counts its rising edges over a gate window.
// Build option RVCO_FM_SATURATE_EN: defined -> edge counter saturates on overflow; undefined -> it wraps.
module rvco_freq_meter #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int GATE_SHIFT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_ena,
  input  logic [NUM_CH-1:0]          i_osc_in,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] i_ch_sel,
  input  logic [7:0]                 i_gate_len,
  input  logic                       i_start,
  output logic [NUM_CH-1:0]          o_osc_rst,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_overflow,
  output logic                       o_err
);
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GATE_MAX = 256 << GATE_SHIFT;
  localparam int TMR_W    = $clog2(((SETTLE_CYC > GATE_MAX) ? SETTLE_CYC : GATE_MAX) + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_DONE} state_t;

  state_t                r_state;
  logic [NUM_CH-1:0]     r_sync1, r_sync2, r_sync3;
  logic [SEL_W-1:0]      r_sel;
  logic [7:0]            r_gate_len;
  logic [TMR_W-1:0]      r_tmr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_cnt_ovf;

  logic [(1<<SEL_W)-1:0] w_edges;
  logic                  w_edge;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_ovf_next;
  logic [TMR_W-1:0]      w_gate_ld;

  // Free-running synchronisers: they keep running outside a measurement so the edge history is clean at gate open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= i_osc_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_comb begin
    w_edges               = '0;
    w_edges[NUM_CH-1:0]   = r_sync2 & ~r_sync3;
  end

  assign w_edge    = (r_state == S_GATE) && w_edges[r_sel];
  assign w_gate_ld = TMR_W'(((int'(r_gate_len) + 1) << GATE_SHIFT) - 1);

  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = r_cnt_ovf;
    if (w_edge) begin
      if (r_cnt == '1) begin
        w_ovf_next = 1'b1;
`ifdef RVCO_FM_SATURATE_EN
        w_cnt_next = r_cnt;
`else
        w_cnt_next = '0;
`endif
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_gate_len <= '0;
      r_tmr      <= '0;
      r_cnt      <= '0;
      r_cnt_ovf  <= 1'b0;
      o_osc_rst  <= '1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && i_ena) begin
            r_sel      <= i_ch_sel;
            r_gate_len <= i_gate_len;
            r_cnt      <= '0;
            r_cnt_ovf  <= 1'b0;
            if (int'(i_ch_sel) >= NUM_CH) begin
              // Invalid channel: report immediately, oscillators stay parked in reset.
              r_state    <= S_DONE;
              o_done     <= 1'b1;
              o_count    <= '0;
              o_overflow <= 1'b0;
              o_err      <= 1'b1;
            end else begin
              r_state   <= S_SETTLE;
              r_tmr     <= TMR_W'(SETTLE_CYC - 1);
              o_busy    <= 1'b1;
              o_osc_rst <= ~(NUM_CH'(1) << i_ch_sel);
            end
          end
        end
        S_SETTLE: begin
          if (!i_ena) begin
            r_state   <= S_IDLE;
            o_busy    <= 1'b0;
            o_osc_rst <= '1;
          end else if (r_tmr == '0) begin
            r_state <= S_GATE;
            r_tmr   <= w_gate_ld;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_GATE: begin
          if (!i_ena) begin
            r_state   <= S_IDLE;
            o_busy    <= 1'b0;
            o_osc_rst <= '1;
          end else begin
            r_cnt     <= w_cnt_next;
            r_cnt_ovf <= w_ovf_next;
            if (r_tmr == '0) begin
              // Last gate cycle: its own edge is folded into the published result.
              r_state    <= S_DONE;
              o_done     <= 1'b1;
              o_count    <= w_cnt_next;
              o_overflow <= w_ovf_next;
              o_err      <= 1'b0;
              o_busy     <= 1'b0;
              o_osc_rst  <= '1;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rvco_freq_meter.sv
// Bench for rvco_freq_meter: two instances (2ch/16-bit and 3ch/4-bit) against a window-count reference model.
module tb_rvco_freq_meter;
  localparam int S  = 16;
  localparam int GS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = '0;
  logic [7:0] gl = '0;
  logic [2:0] osc = '0;

  logic [1:0]  osc_rst0;
  logic        busy0, done0, ovf0, err0;
  logic [15:0] count0;
  logic [2:0]  osc_rst1;
  logic        busy1, done1, ovf1, err1;
  logic [3:0]  count1;

  int ncmp = 0;
  int nerr = 0;
  int k = 0;
  int per [3];
  int ph  [3];
  logic [2:0] hist [0:131071];

  // reference model state per instance (0: 2ch/16b, 1: 3ch/4b)
  bit   m_act [2];
  int   m_t0  [2];
  int   m_g   [2];
  int   m_sel [2];
  bit   e_busy[2];
  bit   e_done[2];
  int   e_cnt [2];
  bit   e_ovf [2];
  bit   e_err [2];
  int   e_rst [2];

  always #5 clk = ~clk;

  rvco_freq_meter #(.NUM_CH(2), .CNT_W(16), .SETTLE_CYC(S), .GATE_SHIFT(GS)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_osc_in(osc[1:0]), .i_ch_sel(sel[0:0]),
    .i_gate_len(gl), .i_start(start), .o_osc_rst(osc_rst0), .o_busy(busy0), .o_done(done0),
    .o_count(count0), .o_overflow(ovf0), .o_err(err0));

  rvco_freq_meter #(.NUM_CH(3), .CNT_W(4), .SETTLE_CYC(S), .GATE_SHIFT(GS)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_osc_in(osc), .i_ch_sel(sel),
    .i_gate_len(gl), .i_start(start), .o_osc_rst(osc_rst1), .o_busy(busy1), .o_done(done1),
    .o_count(count1), .o_overflow(ovf1), .o_err(err1));

  function automatic int nch(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int cmask(input int i); return (i == 0) ? 16'hFFFF : 4'hF; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    ncmp++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d..%0d", nm, k, act, lo, hi);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_cnt[i] = 0;
      e_ovf[i] = 0; e_err[i] = 0; e_rst[i] = (1 << nch(i)) - 1;
    end
  endtask

  // Result = rising transitions of the selected oscillator seen (via 2 sync stages) during the G gate cycles.
  task automatic mstep(input int i);
    bit prev_done;
    int s, n;
    prev_done = e_done[i];
    e_done[i] = 0;
    s = (i == 0) ? int'(sel[0]) : int'(sel);
    if (m_act[i]) begin
      if (!ena) begin
        m_act[i] = 0;
      end else if (k - m_t0[i] == S + m_g[i]) begin
        n = 0;
        for (int j = m_t0[i] + S - 1; j <= m_t0[i] + S + m_g[i] - 2; j++)
          if (hist[j][m_sel[i]] && !hist[j-1][m_sel[i]]) n++;
        e_ovf[i] = (n > cmask(i));
`ifdef RVCO_FM_SATURATE_EN
        e_cnt[i] = e_ovf[i] ? cmask(i) : n;
`else
        e_cnt[i] = n & cmask(i);
`endif
        e_err[i]  = 0;
        e_done[i] = 1;
        m_act[i]  = 0;
      end
    end else if (!prev_done && start && ena) begin
      if (s >= nch(i)) begin
        e_done[i] = 1; e_cnt[i] = 0; e_err[i] = 1; e_ovf[i] = 0;
      end else begin
        m_act[i] = 1; m_t0[i] = k; m_g[i] = (int'(gl) + 1) << GS; m_sel[i] = s;
      end
    end
    e_busy[i] = m_act[i];
    e_rst[i]  = m_act[i] ? (((1 << nch(i)) - 1) & ~(1 << m_sel[i])) : ((1 << nch(i)) - 1);
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) begin
        k++;
        hist[k] = osc;
      end
      if (!rst_n) mreset();
      else for (int i = 0; i < 2; i++) mstep(i);
    end
  end

  initial begin
    for (int c = 0; c < 3; c++) begin per[c] = 0; ph[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        osc[c] = (per[c] == 0) ? 1'b0 : (((k + ph[c]) % per[c]) < per[c] / 2);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy0", busy0, e_busy[0]);
      chk("done0", done0, e_done[0]);
      chk("osc_rst0", osc_rst0, e_rst[0]);
      chk("count0", count0, e_cnt[0]);
      chk("ovf0", ovf0, e_ovf[0]);
      chk("err0", err0, e_err[0]);
      chk("busy1", busy1, e_busy[1]);
      chk("done1", done1, e_done[1]);
      chk("osc_rst1", osc_rst1, e_rst[1]);
      chk("count1", count1, e_cnt[1]);
      chk("ovf1", ovf1, e_ovf[1]);
      chk("err1", err1, e_err[1]);
    end
  end

  task automatic pulse_start(input int s, input int g);
    sel = 2'(s); gl = 8'(g); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done0(input int budget, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done0) begin lat = k - t0 + 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic set_per(input int p0, input int p1, input int p2);
    per[0] = p0; per[1] = p1; per[2] = p2;
    ph[0] = 0; ph[1] = 0; ph[2] = 0;
  endtask

  initial begin
    int t0, lat, nd, g, n;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy0, 0);
    chk("rst_osc_rst0", osc_rst0, 3);
    rst_n = 1'b1;
    ena = 1'b1;
    @(negedge clk);

    // 8-clk oscillator on ch0, 128-cycle gate
    set_per(8, 0, 0);
    pulse_start(0, 7); t0 = k;
    @(negedge clk);
    chk("d1_osc_rst", osc_rst0, 2);
    chk("d1_busy", busy0, 1);
    wait_done0(400, t0, lat);
    chk("d1_latency", lat, 145);
    chk_rng("d1_count", count0, 15, 17);
    chk("d1_ovf", ovf0, 0);
    repeat (3) @(negedge clk);

    // ch1 fast (4), ch0 period 6 as a distractor
    set_per(6, 4, 0);
    pulse_start(1, 15); t0 = k;
    @(negedge clk);
    chk("d2_osc_rst", osc_rst0, 1);
    wait_done0(600, t0, lat);
    chk("d2_latency", lat, 273);
    chk_rng("d2_count", count0, 63, 65);
    repeat (3) @(negedge clk);

    // 4-bit instance overflow: exactly 32 edges
    set_per(0, 4, 0);
    pulse_start(1, 7); t0 = k;
    wait_done0(400, t0, lat);
    chk("d3_ovf_small", ovf1, 1);
`ifdef RVCO_FM_SATURATE_EN
    chk("d3_count_small", count1, 15);
`else
    chk("d3_count_small", count1, 0);
`endif
    chk("d3_count_big", count0, 32);
    repeat (3) @(negedge clk);

    // invalid channel on the 3-channel instance
    pulse_start(3, 0);
    chk("d4_done", done1, 1);
    chk("d4_err", err1, 1);
    chk("d4_count", count1, 0);
    chk("d4_osc_rst", osc_rst1, 7);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b1;
    chk("d4_abort_busy", busy0, 0);

    // abort at gate cycle 20, restart at cycle 50, start-while-busy ignored
    set_per(8, 6, 10);
    pulse_start(0, 3); t0 = k;
    while (k < t0 + S + 20) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    chk("d5_abort_busy", busy0, 0);
    while (k < t0 + 49) @(negedge clk);
    pulse_start(0, 3); t0 = k;
    repeat (10) @(negedge clk);
    pulse_start(1, 0);
    wait_done0(300, t0, lat);
    chk("d5_latency", lat, 81);
    repeat (3) @(negedge clk);

    // async reset mid-gate
    pulse_start(0, 7); t0 = k;
    while (k < t0 + S + 30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("d6_busy", busy0, 0);
    chk("d6_done", done0, 0);
    chk("d6_count", count0, 0);
    chk("d6_ovf", ovf0, 0);
    chk("d6_err", err0, 0);
    chk("d6_osc_rst", osc_rst0, 3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (200) begin
      @(negedge clk);
      if (done0) nd++;
    end
    chk("d6_no_done", nd, 0);

    // randomized traffic with occasional aborts and stray starts
    for (int t = 0; t < 30; t++) begin
      for (int c = 0; c < 3; c++) begin
        per[c] = 2 * $urandom_range(1, 6);
        ph[c]  = $urandom_range(0, 11);
      end
      g = $urandom_range(0, 7);
      pulse_start($urandom_range(0, 3), g);
      n = S + ((g + 1) << GS) + 8;
      for (int i = 0; i < n; i++) begin
        ena   = ($urandom_range(0, 299) != 0);
        start = ($urandom_range(0, 39) == 0);
        sel   = 2'($urandom_range(0, 3));
        gl    = 8'($urandom_range(0, 7));
        @(negedge clk);
      end
      start = 1'b0;
      ena   = 1'b0;
      @(negedge clk);
      ena = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", k);
    $fatal(1, "watchdog");
  end
endmodule
